// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache miss
// handler and the D-cache (miss fills and write-through stores). A granted
// miss is issued as a burst of WORDS_PER_BLOCK word reads. Each returned word
// is steered into the fill port of the cache that owns the burst.
//
// Optional feature (compile-time macro):
//   MEM_ARB_CRIT_WORD_FIRST_EN - the burst starts at the missing word and
//   wraps modulo WORDS_PER_BLOCK. Without the macro, every burst starts at
//   word 0.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no access in flight; requests arbitrated here (store > D > I)
// WRITE  | single-cycle write-through store, acknowledged the same cycle
// FILL   | burst reads being issued and/or returned words being steered
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               icache_miss,
    input  logic [15:0]                        icache_miss_addr,
    input  logic                               dcache_miss,
    input  logic [15:0]                        dcache_miss_addr,
    input  logic                               dcache_wr_req,
    input  logic [15:0]                        dcache_wr_addr,
    input  logic [15:0]                        dcache_wr_data,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [15:0]                        mem_addr,
    output logic [15:0]                        mem_data_out,
    input  logic                               mem_data_valid,
    input  logic [15:0]                        mem_data_in,
    output logic [15:0]                        fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic                               icache_fill_we,
    output logic                               dcache_fill_we,
    output logic                               icache_fill_done,
    output logic                               dcache_fill_done,
    output logic                               dcache_wr_ack,
    output logic                               busy
);

    localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
    localparam int BASE_W = 16 - IDX_W - 1;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_BLOCK - 1);

    // Reject parameter values the address split cannot represent.
    generate
        if (WORDS_PER_BLOCK < 2 || WORDS_PER_BLOCK > 16 ||
            (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_wpb
            $error("mem_arbiter: WORDS_PER_BLOCK must be a power of two in 2..16");
        end
        if (MEM_LATENCY < 1) begin : g_bad_lat
            $error("mem_arbiter: MEM_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                owner_d, owner_d_nxt;      // 1: D-cache owns the burst
    logic [BASE_W-1:0]   base, base_nxt;
    logic [IDX_W-1:0]    issue_cnt, issue_cnt_nxt;
    logic                issue_done, issue_done_nxt;
    logic [IDX_W-1:0]    ret_cnt, ret_cnt_nxt;
    logic [IDX_W-1:0]    issue_word;
    logic [IDX_W-1:0]    ret_word;

`ifdef MEM_ARB_CRIT_WORD_FIRST_EN
    logic [IDX_W-1:0]    start_word, start_word_nxt;

    // Burst positions are offsets from the critical word; the IDX_W-bit add
    // wraps modulo the block size, so the order is start..WPB-1, 0..start-1.
    assign issue_word = start_word + issue_cnt;
    assign ret_word   = start_word + ret_cnt;

    // Critical-word start offset, captured at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_word <= '0;
        end else begin
            start_word <= start_word_nxt;
        end
    end

    // Start offset comes from the winning requester's address at grant.
    always_comb begin
        start_word_nxt = start_word;
        if (state == ST_IDLE && !dcache_wr_req) begin
            if (dcache_miss) begin
                start_word_nxt = dcache_miss_addr[IDX_W:1];
            end else if (icache_miss) begin
                start_word_nxt = icache_miss_addr[IDX_W:1];
            end
        end
    end
`else
    // Sequential bursts: position in the burst is the word index itself.
    assign issue_word = issue_cnt;
    assign ret_word   = ret_cnt;
`endif

    // Byte-select bit is never used, and the word offset is only used when
    // critical-word-first is compiled in.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{icache_miss_addr[IDX_W:0], dcache_miss_addr[IDX_W:0]};

    // State register and burst bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner_d    <= 1'b0;
            base       <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            ret_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            owner_d    <= owner_d_nxt;
            base       <= base_nxt;
            issue_cnt  <= issue_cnt_nxt;
            issue_done <= issue_done_nxt;
            ret_cnt    <= ret_cnt_nxt;
        end
    end

    // Next-state, counter updates and all outputs. Every output is zero
    // in IDLE, so an asynchronous reset clears them immediately.
    always_comb begin
        state_nxt        = state;
        owner_d_nxt      = owner_d;
        base_nxt         = base;
        issue_cnt_nxt    = issue_cnt;
        issue_done_nxt   = issue_done;
        ret_cnt_nxt      = ret_cnt;

        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_data_out     = '0;
        fill_data        = '0;
        fill_word_idx    = '0;
        icache_fill_we   = 1'b0;
        dcache_fill_we   = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        dcache_wr_ack    = 1'b0;
        busy             = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                issue_cnt_nxt  = '0;
                issue_done_nxt = 1'b0;
                ret_cnt_nxt    = '0;
                // Stores first, then the D-side miss (older instruction),
                // and the I-side miss last.
                if (dcache_wr_req) begin
                    state_nxt = ST_WRITE;
                end else if (dcache_miss) begin
                    state_nxt   = ST_FILL;
                    owner_d_nxt = 1'b1;
                    base_nxt    = dcache_miss_addr[15:IDX_W+1];
                end else if (icache_miss) begin
                    state_nxt   = ST_FILL;
                    owner_d_nxt = 1'b0;
                    base_nxt    = icache_miss_addr[15:IDX_W+1];
                end
            end

            ST_WRITE: begin
                mem_en        = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = dcache_wr_addr;
                mem_data_out  = dcache_wr_data;
                dcache_wr_ack = 1'b1;
                state_nxt     = ST_IDLE;
            end

            ST_FILL: begin
                // Issue side: one read per cycle until the whole block is out.
                if (!issue_done) begin
                    mem_en        = 1'b1;
                    mem_addr      = {base, issue_word, 1'b0};
                    issue_cnt_nxt = issue_cnt + 1'b1;
                    if (issue_cnt == LAST_WORD) begin
                        issue_done_nxt = 1'b1;
                    end
                end
                // Return side: steer each valid word to the owning cache;
                // the block-sized count of returns ends the burst.
                if (mem_data_valid) begin
                    fill_data      = mem_data_in;
                    fill_word_idx  = ret_word;
                    icache_fill_we = !owner_d;
                    dcache_fill_we = owner_d;
                    ret_cnt_nxt    = ret_cnt + 1'b1;
                    if (ret_cnt == LAST_WORD) begin
                        icache_fill_done = !owner_d;
                        dcache_fill_done = owner_d;
                        state_nxt        = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
